// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state enum, LS operation
// codes, Length size codes, the default request timeout, and small helpers
// that decode a size code into lane enables and replicated store data.
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } lsu_state_e;

  // LS operation codes (11 is unused and behaves like none)
  localparam logic [1:0] LS_NONE   = 2'b00;
  localparam logic [1:0] LS_LOAD   = 2'b01;
  localparam logic [1:0] LS_STORE  = 2'b10;
  localparam logic [1:0] LS_UNUSED = 2'b11;

  // Length size codes; bit 2 selects zero-extension on loads
  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 16;

  function automatic logic len_legal(input logic [2:0] len);
    logic ok;
    case (len)
      LEN_B, LEN_H, LEN_W, LEN_BU, LEN_HU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Size is carried in the low two bits for every legal code.
  function automatic logic misaligned(input logic [2:0] len, input logic [1:0] a);
    logic bad;
    case (len[1:0])
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] len, input logic [1:0] a);
    logic [3:0] be;
    case (len[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] len, input logic [31:0] data);
    logic [31:0] wd;
    case (len[1:0])
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Picks the addressed byte/halfword out of a memory read word and extends it
// to 32 bits: sign-extended for LB/LH, zero-extended for LBU/LHU, passthrough
// for LW.
// Ports:
//   rdata   in  32  word returned by memory
//   length  in   3  Length code of the load
//   addr_lo in   2  low address bits selecting the lane
//   rd_val  out 32  extended value for the register file
// ---------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  length,
  input  logic [1:0]  addr_lo,
  output logic [31:0] rd_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (length)
      LEN_B:   rd_val = {{24{byte_sel[7]}}, byte_sel};
      LEN_BU:  rd_val = {24'h000000, byte_sel};
      LEN_H:   rd_val = {{16{half_sel[15]}}, half_sel};
      LEN_HU:  rd_val = {16'h0000, half_sel};
      default: rd_val = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns a load/store request from the ALU into a single word-aligned memory
// transaction, checks alignment/size, waits for mem_ack with a timeout, and
// returns extended load data to the register file.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   LS, Length            operation (none/load/store) and access size
//   addr, rs2             effective address and store data
//   DONE_ALU, Next_INST   start strobe (IDLE only) and completion acknowledge
//   rd                    extended load data, held until the next load
//   DONE_LS, LS_ERR       completion and error flags (held until Next_INST)
//   mem_req, mem_we       memory request / write enable
//   mem_addr, mem_be      word address and byte enables
//   mem_wdata             lane-replicated store data
//   mem_rdata, mem_ack    read data and one-cycle completion pulse
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  LS,
  input  logic [2:0]  Length,
  input  logic [31:0] addr,
  input  logic [31:0] rs2,
  input  logic        DONE_ALU,
  input  logic        Next_INST,
  output logic [31:0] rd,
  output logic        DONE_LS,
  output logic        LS_ERR,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  len_q, len_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] ext_val;
  logic        start_op;

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .length  (len_q),
    .addr_lo (addr_lo_q),
    .rd_val  (ext_val)
  );

  assign start_op = DONE_ALU && ((LS == LS_LOAD) || (LS == LS_STORE));

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    len_d       = len_q;
    addr_lo_d   = addr_lo_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;

    case (state_q)
      S_IDLE: begin
        if (start_op) begin
          if (!len_legal(Length) || misaligned(Length, addr[1:0])) begin
            state_d = S_ERR;
          end else begin
            store_d     = (LS == LS_STORE);
            len_d       = Length;
            addr_lo_d   = addr[1:0];
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = lane_be(Length, addr[1:0]);
            mem_wdata_d = lane_wdata(Length, rs2);
            cnt_d       = '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        // ack is checked first so an ack on the final cycle still completes
        if (mem_ack) begin
          if (!store_q) rd_d = ext_val;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (Next_INST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      len_q       <= '0;
      addr_lo_q   <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      len_q       <= len_d;
      addr_lo_q   <= addr_lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
    end
  end

  assign rd        = rd_q;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = (state_q == S_REQ) && store_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign DONE_LS   = (state_q == S_DONE) || (state_q == S_ERR);
  assign LS_ERR    = (state_q == S_ERR);

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed testbench for load_store_unit with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  LS;
  logic [2:0]  Length;
  logic [31:0] addr;
  logic [31:0] rs2;
  logic        DONE_ALU;
  logic        Next_INST;
  logic [31:0] rd;
  logic        DONE_LS;
  logic        LS_ERR;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int numCompared   = 0;
  int numMismatched = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .LS        (LS),
    .Length    (Length),
    .addr      (addr),
    .rs2       (rs2),
    .DONE_ALU  (DONE_ALU),
    .Next_INST (Next_INST),
    .rd        (rd),
    .DONE_LS   (DONE_LS),
    .LS_ERR    (LS_ERR),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive a start request in IDLE and advance one cycle (DUT enters REQ/ERR)
  task automatic applyStimulus(input logic [1:0] ls, input logic [2:0] len,
                               input logic [31:0] a, input logic [31:0] data);
    LS       = ls;
    Length   = len;
    addr     = a;
    rs2      = data;
    DONE_ALU = 1'b1;
    @(negedge clk);
    DONE_ALU = 1'b0;
  endtask

  // Pulse mem_ack with read data for one cycle
  task automatic ackMem(input logic [31:0] data);
    mem_rdata = data;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
  endtask

  // Pulse Next_INST for one cycle to return to IDLE
  task automatic nextInst();
    Next_INST = 1'b1;
    @(negedge clk);
    Next_INST = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req"},  {31'd0, mem_req}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, DONE_LS}, 32'd0);
    checkOutput({tag, "_err"},  {31'd0, LS_ERR},  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; LS = 2'b00; Length = 3'b000; addr = '0; rs2 = '0;
    DONE_ALU = 1'b0; Next_INST = 1'b0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkIdleOutputs("rst");
    checkOutput("rst_rd",    rd, 32'd0);
    checkOutput("rst_we",    {31'd0, mem_we}, 32'd0);
    checkOutput("rst_be",    {28'd0, mem_be}, 32'd0);
    checkOutput("rst_addr",  mem_addr, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store word, ack in first REQ cycle
    applyStimulus(2'b10, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    checkOutput("sw_req",   {31'd0, mem_req}, 32'd1);
    checkOutput("sw_we",    {31'd0, mem_we},  32'd1);
    checkOutput("sw_be",    {28'd0, mem_be},  32'h0000_000F);
    checkOutput("sw_wdata", mem_wdata,        32'hDEAD_BEEF);
    checkOutput("sw_addr",  mem_addr,         32'h0000_0100);
    checkOutput("sw_done0", {31'd0, DONE_LS}, 32'd0);
    ackMem(32'h0);
    checkOutput("sw_done",  {31'd0, DONE_LS}, 32'd1);
    checkOutput("sw_err",   {31'd0, LS_ERR},  32'd0);
    checkOutput("sw_reqoff",{31'd0, mem_req}, 32'd0);
    checkOutput("sw_rd",    rd,               32'd0);
    @(negedge clk);
    checkOutput("sw_hold",  {31'd0, DONE_LS}, 32'd1);
    nextInst();
    checkIdleOutputs("sw_idle");

    // LB at 0x103
    applyStimulus(2'b01, 3'b000, 32'h0000_0103, 32'h0);
    checkOutput("lb_be",   {28'd0, mem_be},  32'h0000_0008);
    checkOutput("lb_we",   {31'd0, mem_we},  32'd0);
    checkOutput("lb_addr", mem_addr,         32'h0000_0100);
    ackMem(32'h8011_2233);
    checkOutput("lb_rd",   rd,               32'hFFFF_FF80);
    nextInst();

    // LBU at 0x103
    applyStimulus(2'b01, 3'b100, 32'h0000_0103, 32'h0);
    ackMem(32'h8011_2233);
    checkOutput("lbu_rd",  rd,               32'h0000_0080);
    nextInst();

    // LH at 0x102 (upper half, negative)
    applyStimulus(2'b01, 3'b001, 32'h0000_0102, 32'h0);
    checkOutput("lh_be",   {28'd0, mem_be},  32'h0000_000C);
    ackMem(32'h8011_2233);
    checkOutput("lh_rd",   rd,               32'hFFFF_8011);
    nextInst();

    // LHU at 0x100 (lower half)
    applyStimulus(2'b01, 3'b101, 32'h0000_0100, 32'h0);
    ackMem(32'h8011_A233);
    checkOutput("lhu_rd",  rd,               32'h0000_A233);
    nextInst();

    // LW at 0x104
    applyStimulus(2'b01, 3'b010, 32'h0000_0104, 32'h0);
    checkOutput("lw_addr", mem_addr,         32'h0000_0104);
    ackMem(32'h1234_5678);
    checkOutput("lw_rd",   rd,               32'h1234_5678);
    nextInst();

    // Store half at 0x102; rd must hold
    applyStimulus(2'b10, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
    checkOutput("sh_be",    {28'd0, mem_be}, 32'h0000_000C);
    checkOutput("sh_wdata", mem_wdata,       32'hABCD_ABCD);
    ackMem(32'hFFFF_FFFF);
    checkOutput("sh_rd",    rd,              32'h1234_5678);
    nextInst();

    // Store byte at 0x101
    applyStimulus(2'b10, 3'b000, 32'h0000_0101, 32'h1234_565A);
    checkOutput("sb_be",    {28'd0, mem_be}, 32'h0000_0002);
    checkOutput("sb_wdata", mem_wdata,       32'h5A5A_5A5A);
    ackMem(32'h0);
    nextInst();

    // Misaligned LW at 0x101
    applyStimulus(2'b01, 3'b010, 32'h0000_0101, 32'h0);
    checkOutput("mis_req",  {31'd0, mem_req}, 32'd0);
    checkOutput("mis_done", {31'd0, DONE_LS}, 32'd1);
    checkOutput("mis_err",  {31'd0, LS_ERR},  32'd1);
    checkOutput("mis_rd",   rd,               32'h1234_5678);
    nextInst();
    checkIdleOutputs("mis_idle");

    // Illegal Length 011
    applyStimulus(2'b01, 3'b011, 32'h0000_0100, 32'h0);
    checkOutput("ill_err",  {31'd0, LS_ERR},  32'd1);
    nextInst();

    // LS=11 is treated as no operation
    applyStimulus(2'b11, 3'b010, 32'h0000_0100, 32'h0);
    checkIdleOutputs("ls11");

    // mem_ack outside REQ is ignored
    ackMem(32'hCAFE_F00D);
    checkOutput("stray_ack_rd", rd, 32'h1234_5678);

    // Timeout with no ack
    applyStimulus(2'b01, 3'b010, 32'h0000_0200, 32'h0);
    repeat (15) @(negedge clk);
    checkOutput("to_req16", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    checkOutput("to_reqoff", {31'd0, mem_req}, 32'd0);
    checkOutput("to_err",    {31'd0, LS_ERR},  32'd1);
    checkOutput("to_done",   {31'd0, DONE_LS}, 32'd1);
    nextInst();

    // Ack on REQ cycle 16 wins over timeout
    applyStimulus(2'b01, 3'b010, 32'h0000_0200, 32'h0);
    repeat (15) @(negedge clk);
    ackMem(32'h0BAD_CAFE);
    checkOutput("ack16_err",  {31'd0, LS_ERR},  32'd0);
    checkOutput("ack16_done", {31'd0, DONE_LS}, 32'd1);
    checkOutput("ack16_rd",   rd,               32'h0BAD_CAFE);

    // DONE_ALU in the same cycle as Next_INST is ignored
    LS = 2'b01; Length = 3'b010; addr = 32'h0000_0300;
    DONE_ALU = 1'b1; Next_INST = 1'b1;
    @(negedge clk);
    DONE_ALU = 1'b0; Next_INST = 1'b0;
    @(negedge clk);
    checkIdleOutputs("same_cyc");

    // Reset in the middle of REQ
    applyStimulus(2'b01, 3'b010, 32'h0000_0300, 32'h0);
    checkOutput("mid_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req",  {31'd0, mem_req}, 32'd0);
    checkOutput("mid_rst_rd",   rd,               32'd0);
    checkOutput("mid_rst_be",   {28'd0, mem_be},  32'd0);
    checkOutput("mid_rst_addr", mem_addr,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(2'b10, 3'b010, 32'h0000_0400, 32'h5555_AAAA);
    checkOutput("post_rst_req",   {31'd0, mem_req}, 32'd1);
    checkOutput("post_rst_wdata", mem_wdata,        32'h5555_AAAA);
    ackMem(32'h0);
    checkOutput("post_rst_done",  {31'd0, DONE_LS}, 32'd1);
    nextInst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum REQ-state cycles waited for mem_ack before error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 LS  input  2  operation: 00 none, 01 load, 10 store, 11 unused (treated as none).
REQ-005 Length  input  3  size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes illegal.
REQ-006 addr  input  32  effective byte address from ALU.
REQ-007 rs2  input  32  store data from the register file.
REQ-008 DONE_ALU  input  1  start strobe; sampled only in IDLE.
REQ-009 Next_INST  input  1  acknowledges completion and returns the unit to IDLE.
REQ-010 rd  output  32  extended load data to the register file.
REQ-011 DONE_LS  output  1  operation complete (load, store or error).
REQ-012 LS_ERR  output  1  misaligned address, illegal Length, or timeout.
REQ-013 mem_req/mem_we  output  1 each  memory request and write-enable.
REQ-014 mem_addr  output  32  word-aligned address, always {addr[31:2],2'b00}.
REQ-015 mem_be  output  4  byte enables; mem_wdata  output  32  store data.
REQ-016 mem_rdata  input  32 and mem_ack  input  1  read data and one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-018 IDLE with DONE_ALU=1 and LS=00 or 11 SHALL leave state unchanged.
REQ-019 IDLE with DONE_ALU=1 and LS=01/10 SHALL go to ERR for illegal Length, LH/LHU/store-half with addr[0]=1, or LW/store-word with addr[1:0]!=0.
REQ-020 In every other IDLE start case it SHALL register op, Length, addr[1:0], mem_addr, mem_be and mem_wdata, then go to REQ.
REQ-021 In REQ, mem_req SHALL be 1 and all mem_* outputs SHALL stay stable until mem_ack.
REQ-022 Store lanes: byte uses be=1<<addr[1:0] with rs2[7:0] replicated x4; half uses be=0011 or 1100 with rs2[15:0] replicated x2; word uses be=1111.
REQ-023 Loads SHALL drive mem_we=0 and mem_be per the same lane rule.
REQ-024 On mem_ack in REQ: a load SHALL capture rd from the addressed lane, sign-extended for 000/001 and zero-extended for 100/101; the FSM SHALL then go to DONE.
REQ-025 DONE_LS SHALL assert the cycle after mem_ack; with ack in the first REQ cycle, DONE_LS is high 2 cycles after the DONE_ALU sample.
REQ-026 A REQ wait counter SHALL reach TIMEOUT cycles without ack, then go to ERR with mem_req deasserted.
REQ-027 mem_ack and timeout in the same cycle: ack SHALL win.
REQ-028 DONE: DONE_LS=1, LS_ERR=0; ERR: DONE_LS=1, LS_ERR=1; both SHALL hold until Next_INST=1, then go to IDLE.
REQ-029 DONE_ALU outside IDLE, including the same cycle as Next_INST, SHALL be ignored; mem_ack outside REQ SHALL be ignored.
REQ-030 rd SHALL change only on a completed load and hold its value through stores and errors.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, counter 0, rd=0, DONE_LS=0, LS_ERR=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset during REQ SHALL abandon the transaction without waiting for mem_ack.

Structure
REQ-033 Shared package lsu_pkg SHALL hold the state enum, LS encodings, Length encodings and the TIMEOUT default.
REQ-034 Lane extraction and extension SHALL be one combinational sub-module, load_extend (rdata, Length, addr[1:0] -> rd value).

Verification
REQ-035 Store word: LS=10, Length=010, addr=0x100, rs2=0xDEADBEEF, ack in 1st REQ cycle -> mem_be=1111, mem_wdata=0xDEADBEEF, mem_addr=0x100, DONE_LS after 2 cycles.
REQ-036 LB vs LBU: addr=0x103, mem_rdata=0x80112233 -> Length=000 gives rd=0xFFFFFF80; Length=100 gives rd=0x00000080.
REQ-037 Store half: addr=0x102, rs2=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD.
REQ-038 Misaligned LW at addr=0x101 -> no mem_req, DONE_LS=1 and LS_ERR=1 next cycle; Next_INST -> IDLE.
REQ-039 No ack with TIMEOUT=16 -> mem_req drops and LS_ERR=1 after 16 REQ cycles; ack on cycle 16 instead -> normal DONE.
REQ-040 rst_n low mid-REQ -> mem_req=0 immediately, all outputs 0; next DONE_ALU starts cleanly.
